alu_result_i2c_tx: RTL and testbench

//  Downstream of the 2A+4B+Cin arithmetic stage: takes its 16-bit result {sum_hi,sum_lo}.

---
 rtl/alu_tx_pkg.sv | 24 ++
 rtl/alu_result_i2c_tx_fifo.sv | 58 +++++
 rtl/alu_result_i2c_tx.sv | 179 +++++++++++++++++
 tb/tb_alu_result_i2c_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_tx_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
// ALU_TX_CHECKSUM_EN adds a third (hi^lo) byte to every word.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ACK,
    DONE
  } state_t;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

`ifdef ALU_TX_CHECKSUM_EN
  localparam int unsigned BYTES_PER_WORD = 3;
`else
  localparam int unsigned BYTES_PER_WORD = 2;
`endif

  localparam int unsigned BYTE_IDX_W = 2;

endpackage

// File: rtl/alu_result_i2c_tx_fifo.sv
// Synchronous result FIFO; ready reflects registered occupancy only.
module result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      ready <= (count_d < CNT_W'(DEPTH));
    end
  end

  // Storage is not reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_result_i2c_tx.sv
// Buffers 2*DATA_W ALU results and shifts each out as I2C-style bytes (hi first, MSB first).
// Optional macro ALU_TX_CHECKSUM_EN appends a hi^lo checksum byte with its own ACK slot.
module alu_result_i2c_tx
  import alu_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sum_lo,
  input  logic [DATA_W-1:0] sum_hi,
  output logic              scl_o,
  output logic              sda_o,
  output logic              sda_oe,
  input  logic              sda_i,
  output logic              busy,
  output logic              done,
  output logic              nack_err
);

  localparam int unsigned WORD_W  = 2 * DATA_W;
  localparam int unsigned SHREG_W = BYTES_PER_WORD * DATA_W;
  localparam int unsigned HP_W    = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(DATA_W);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t                state, state_d;
  logic [HP_W-1:0]       hp_cnt, hp_d;
  logic                  phase_hi, phase_d;
  logic [BIT_W-1:0]      bit_cnt, bit_d;
  logic [BYTE_IDX_W-1:0] byte_idx, byte_d;
  logic [SHREG_W-1:0]    shreg, shreg_d;
  logic                  scl_d, sda_d, oe_d, busy_d, done_d, nack_d;
  logic                  push_c, pop_c;
  logic [WORD_W-1:0]     fifo_rdata_c;
  logic [CNT_W-1:0]      fifo_count;
  logic [SHREG_W-1:0]    load_word;
  logic                  hp_end, bit_end, last_byte, fifo_has_word;

  assign push_c = in_valid && in_ready;

  result_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wdata   ({sum_hi, sum_lo}),
    .pop     (pop_c),
    .rdata_c (fifo_rdata_c),
    .count   (fifo_count),
    .ready   (in_ready)
  );

`ifdef ALU_TX_CHECKSUM_EN
  assign load_word = {fifo_rdata_c, fifo_rdata_c[WORD_W-1 -: DATA_W] ^ fifo_rdata_c[DATA_W-1:0]};
`else
  assign load_word = fifo_rdata_c;
`endif

  assign hp_end        = (hp_cnt == HP_W'(CLK_DIV - 1));
  assign bit_end       = (bit_cnt == BIT_W'(DATA_W - 1));
  assign last_byte     = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign fifo_has_word = (fifo_count != '0);

  // Next state, counters and registered-output values.
  always_comb begin
    state_d  = state;
    hp_d     = hp_cnt;
    phase_d  = phase_hi;
    bit_d    = bit_cnt;
    byte_d   = byte_idx;
    shreg_d  = shreg;
    pop_c    = 1'b0;
    done_d   = 1'b0;
    nack_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (fifo_has_word) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (!hp_end) begin
          hp_d = hp_cnt + HP_W'(1);
        end else begin
          hp_d    = '0;
          phase_d = !phase_hi;
          if (phase_hi) begin
            shreg_d = shreg << 1;
            if (bit_end) begin
              bit_d   = '0;
              state_d = ACK;
            end else begin
              bit_d = bit_cnt + BIT_W'(1);
            end
          end
        end
      end
      ACK: begin
        if (!hp_end) begin
          hp_d = hp_cnt + HP_W'(1);
        end else begin
          hp_d    = '0;
          phase_d = !phase_hi;
          if (phase_hi) begin
            if (sda_i == NACK_BIT) begin
              nack_d  = 1'b1;
              state_d = IDLE;
            end else if (last_byte) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              byte_d  = byte_idx + BYTE_IDX_W'(1);
              state_d = SHIFT;
            end
          end
        end
      end
      DONE: begin
        state_d = fifo_has_word ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The pop happens on the edge entering LOAD, so LOAD already holds the word.
    if ((state_d == LOAD) && (state != LOAD)) begin
      pop_c   = 1'b1;
      shreg_d = load_word;
      byte_d  = '0;
      bit_d   = '0;
      hp_d    = '0;
      phase_d = 1'b0;
    end

    scl_d  = !(((state_d == SHIFT) || (state_d == ACK)) && !phase_d);
    oe_d   = (state_d == SHIFT);
    sda_d  = (state_d == SHIFT) ? shreg_d[SHREG_W-1] : 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hp_cnt   <= '0;
      phase_hi <= 1'b0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      scl_o    <= 1'b1;
      sda_o    <= 1'b1;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      state    <= state_d;
      hp_cnt   <= hp_d;
      phase_hi <= phase_d;
      bit_cnt  <= bit_d;
      byte_idx <= byte_d;
      shreg    <= shreg_d;
      scl_o    <= scl_d;
      sda_o    <= sda_d;
      sda_oe   <= oe_d;
      busy     <= busy_d;
      done     <= done_d;
      nack_err <= nack_d;
    end
  end

endmodule

// File: tb/tb_alu_result_i2c_tx.sv
// Directed bench for alu_result_i2c_tx; honours ALU_TX_CHECKSUM_EN for byte count and word timing.
module tb_alu_result_i2c_tx;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CLK_DIV    = 4;
`ifdef ALU_TX_CHECKSUM_EN
  localparam int NBYTES = 3;
  localparam logic [31:0] EXP_T2 = 32'h0001A5A4;
`else
  localparam int NBYTES = 2;
  localparam logic [31:0] EXP_T2 = 32'h000001A5;
`endif
  localparam int WORD_CYC = 18 * CLK_DIV * NBYTES + 2;
  localparam int NACK_CYC = 18 * CLK_DIV + 2;

  logic clk, rst_n, in_valid, in_ready, scl_o, sda_o, sda_oe, sda_i, busy, done, nack_err;
  logic [DATA_W-1:0] sum_lo, sum_hi;

  alu_result_i2c_tx #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_lo   (sum_lo),
    .sum_hi   (sum_hi),
    .scl_o    (scl_o),
    .sda_o    (sda_o),
    .sda_oe   (sda_oe),
    .sda_i    (sda_i),
    .busy     (busy),
    .done     (done),
    .nack_err (nack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic prev_scl = 1'b1;
  logic bitq[$];
  int   ack_slots = 0;
  int   done_cyc[$];
  int   nack_cnt = 0;
  logic [15:0] words [4] = '{16'h1234, 16'hFF00, 16'h00FF, 16'h8001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock; observe outputs just after the edge and log bus events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (scl_o && !prev_scl) begin
      if (sda_oe) bitq.push_back(sda_o);
      else ack_slots++;
    end
    prev_scl = scl_o;
    if (done) done_cyc.push_back(cyc);
    if (nack_err) nack_cnt++;
  endtask

  function automatic logic [31:0] bits_at(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (base + i < bitq.size()) v = {v[30:0], bitq[base+i]};
      else v = {v[30:0], 1'bx};
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_stream(input logic [15:0] w);
`ifdef ALU_TX_CHECKSUM_EN
    return {8'h00, w, w[15:8] ^ w[7:0]};
`else
    return {16'h0000, w};
`endif
  endfunction

  task automatic push_word(input logic [15:0] w, output int acc_cyc);
    int g = 0;
    {sum_hi, sum_lo} = w;
    in_valid = 1'b1;
    while (!in_ready && g < 400) begin
      tick();
      g++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  initial begin
    int c0, c1, base, a0, d0, n0, g, k, lat;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; sum_lo = '0; sum_hi = '0; sda_i = 1'b0;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_scl",      32'(scl_o),    32'd1);
    check("rst_sda",      32'(sda_o),    32'd1);
    check("rst_oe",       32'(sda_oe),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_nack",     32'(nack_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_busy",     32'(busy),     32'd0);

    // Single word, all bytes ACKed
    base = bitq.size(); a0 = ack_slots; d0 = done_cyc.size();
    push_word(16'h01A5, c0);
    tick();
    check("t2_load_busy", 32'(busy),  32'd1);
    check("t2_load_scl",  32'(scl_o), 32'd1);
    tick();
    check("t2_first_low", 32'(scl_o),  32'd0);
    check("t2_first_oe",  32'(sda_oe), 32'd1);
    check("t2_first_bit", 32'(sda_o),  32'd0);
    g = 0;
    while (done_cyc.size() == d0 && g < 600) begin tick(); g++; end
    check("t2_done_cnt", 32'(done_cyc.size() - d0), 32'd1);
    lat = (done_cyc.size() > d0) ? done_cyc[$] - c0 : -1;
    check("t2_done_lat", 32'(lat), 32'(WORD_CYC));
    check("t2_nbits", 32'(bitq.size() - base), 32'(8 * NBYTES));
    check("t2_bits",  bits_at(base, 8 * NBYTES), EXP_T2);
    check("t2_acks",  32'(ack_slots - a0), 32'(NBYTES));
    tick();
    check("t2_idle_busy", 32'(busy),   32'd0);
    check("t2_idle_scl",  32'(scl_o),  32'd1);
    check("t2_idle_oe",   32'(sda_oe), 32'd0);

    // NACK on the first byte aborts the word
    sda_i = 1'b1;
    base = bitq.size(); a0 = ack_slots; d0 = done_cyc.size(); n0 = nack_cnt;
    push_word(16'h01A5, c0);
    g = 0;
    while (nack_cnt == n0 && g < 300) begin tick(); g++; end
    check("t3_nack_cnt", 32'(nack_cnt - n0), 32'd1);
    check("t3_nack_lat", 32'(cyc - c0), 32'(NACK_CYC));
    check("t3_busy",     32'(busy), 32'd0);
    repeat (100) tick();
    check("t3_nbits", 32'(bitq.size() - base), 32'd8);
    check("t3_bits",  bits_at(base, 8), 32'h01);
    check("t3_acks",  32'(ack_slots - a0), 32'd1);
    check("t3_no_done", 32'(done_cyc.size() - d0), 32'd0);
    check("t3_one_pulse", 32'(nack_cnt - n0), 32'd1);
    sda_i = 1'b0;

    // Four words with in_valid held
    base = bitq.size(); a0 = ack_slots; d0 = done_cyc.size();
    k = 0; g = 0;
    {sum_hi, sum_lo} = words[0];
    in_valid = 1'b1;
    while (k < 4 && g < 1200) begin
      acc = in_ready;
      tick();
      if (acc) begin
        k++;
        if (k == 3) check("t4_ready_after3", 32'(in_ready), 32'd0);
        if (k < 4) {sum_hi, sum_lo} = words[k];
      end
      g++;
    end
    in_valid = 1'b0;
    check("t4_accepted", 32'(k), 32'd4);
    g = 0;
    while (done_cyc.size() - d0 < 4 && g < 2000) begin tick(); g++; end
    check("t4_done_cnt", 32'(done_cyc.size() - d0), 32'd4);
    for (int w = 1; w < 4; w++) begin
      lat = (done_cyc.size() > d0 + w) ? done_cyc[d0+w] - done_cyc[d0+w-1] : -1;
      check($sformatf("t4_spacing%0d", w), 32'(lat), 32'(WORD_CYC));
    end
    check("t4_nbits", 32'(bitq.size() - base), 32'(32 * NBYTES));
    for (int w = 0; w < 4; w++) begin
      check($sformatf("t4_word%0d", w), bits_at(base + w * 8 * NBYTES, 8 * NBYTES), exp_stream(words[w]));
    end
    check("t4_acks", 32'(ack_slots - a0), 32'(4 * NBYTES));

    // Reset mid-byte with a second word still queued
    base = bitq.size(); d0 = done_cyc.size(); n0 = nack_cnt;
    push_word(16'hC3C3, c0);
    push_word(16'h5A5A, c1);
    g = 0;
    while (bitq.size() - base < 3 && g < 200) begin tick(); g++; end
    check("t5_three_bits", 32'(bitq.size() - base), 32'd3);
    rst_n = 1'b0;
    tick();
    check("t5_scl",  32'(scl_o),    32'd1);
    check("t5_oe",   32'(sda_oe),   32'd0);
    check("t5_busy", 32'(busy),     32'd0);
    check("t5_done", 32'(done),     32'd0);
    check("t5_nack", 32'(nack_err), 32'd0);
    check("t5_rdy",  32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t5_rel_rdy", 32'(in_ready), 32'd1);
    repeat (60) tick();
    check("t5_flushed",  32'(busy), 32'd0);
    check("t5_no_bits",  32'(bitq.size() - base), 32'd3);
    check("t5_no_done",  32'(done_cyc.size() - d0), 32'd0);
    check("t5_no_nack",  32'(nack_cnt - n0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
